// File: rtl/scan_sel.sv
// -----------------------------------------------------------------------------
// scan_sel -- masked round-robin scan index generator.
//
// Steps a 3-bit index through the set bits of an 8-bit participation mask. Each
// index is held for one scan slot of DIV clock cycles. A one-cycle scan_done
// pulse marks the advance that closes a full pass, which is any advance where
// the next index is not above the current one.
//
// Optional feature (macro SCAN_BLANK_EN): after every shown slot a blank slot
// of DIV cycles is inserted. During the blank slot sel already carries the next
// index and sel_vld is low. Without the macro the BLANK state does not exist.
//
// Parameters:
//   DIV        clock cycles per scan slot (1..65535)
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   en         scan enable; dropping it returns to IDLE immediately
//   mask[7:0]  participation mask, bit i=1 means index i is scanned
//   sel[2:0]   current scan index (registered)
//   sel_vld    sel is to be driven active downstream (registered)
//   scan_done  one-cycle pulse on the advance that completes a pass (registered)
// -----------------------------------------------------------------------------
module scan_sel #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] mask,
  output logic [2:0] sel,
  output logic       sel_vld,
  output logic       scan_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
`ifdef SCAN_BLANK_EN
    BLANK = 2'd2,
`endif
    SHOW  = 2'd1
  } state_t;

  localparam logic [15:0] LAST = 16'(DIV - 1);

  state_t      state;
  logic [15:0] cnt;
  logic        tick;
  logic [2:0]  nxt;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // First set bit searching cur+1, cur+2, ... wrapping, with cur itself last.
  // The mask is rotated so bit j of rot stands for index cur+1+j (mod 8).
  function automatic logic [2:0] next_set(input logic [7:0] m, input logic [2:0] cur);
    logic [15:0] dbl;
    logic [7:0]  rot;
    dbl = {m, m} >> ({1'b0, cur} + 4'd1);
    rot = dbl[7:0];
    return cur + 3'd1 + lowest_set(rot);
  endfunction

  // Slot-end strobe and the candidate for the next advance.
  always_comb begin
    tick = (cnt == LAST);
    nxt  = next_set(mask, sel);
  end

  // Scan state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 16'd0;
      sel       <= 3'd0;
      sel_vld   <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 16'd0;
          if (en && (mask != 8'd0)) begin
            state   <= SHOW;
            sel     <= lowest_set(mask);
            sel_vld <= 1'b1;
          end else begin
            sel_vld <= 1'b0;
          end
        end
        SHOW: begin
          // Loss of enable or of every mask bit wins over a pending tick.
          if (!en || (mask == 8'd0)) begin
            state   <= IDLE;
            cnt     <= 16'd0;
            sel_vld <= 1'b0;
          end else if (tick) begin
            cnt       <= 16'd0;
            sel       <= nxt;
            scan_done <= (nxt <= sel);
`ifdef SCAN_BLANK_EN
            state     <= BLANK;
            sel_vld   <= 1'b0;
`else
            sel_vld   <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`ifdef SCAN_BLANK_EN
        BLANK: begin
          if (!en || (mask == 8'd0)) begin
            state   <= IDLE;
            cnt     <= 16'd0;
            sel_vld <= 1'b0;
          end else if (tick) begin
            state   <= SHOW;
            cnt     <= 16'd0;
            sel_vld <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`endif
        default: begin
          state   <= IDLE;
          cnt     <= 16'd0;
          sel_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_sel.sv
// -----------------------------------------------------------------------------
// tb_scan_sel -- self-checking bench for scan_sel (DIV=4).
// A cycle model pushes the expected outputs for each clock edge into a queue;
// after the edge they are popped and compared with the DUT outputs. Directed
// checks against fixed values cover the documented scan scenarios.
// -----------------------------------------------------------------------------
module tb_scan_sel;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] mask = 8'd0;
  logic [2:0] sel;
  logic       sel_vld;
  logic       scan_done;

  always #5 clk = ~clk;

  scan_sel #(.DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mask      (mask),
    .sel       (sel),
    .sel_vld   (sel_vld),
    .scan_done (scan_done)
  );

  typedef struct packed {
    logic [2:0] sel;
    logic       vld;
    logic       done;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;

  // reference model state: 0 idle, 1 show, 2 blank
  int         m_state = 0;
  int         m_cnt = 0;
  logic [2:0] m_sel = 3'd0;
  logic       m_vld = 1'b0;
  logic       m_done = 1'b0;

  function automatic logic [2:0] m_lowest(input logic [7:0] m);
    for (int k = 0; k < 8; k++) if (m[k]) return 3'(k);
    return 3'd0;
  endfunction

  function automatic logic [2:0] m_next(input logic [7:0] m, input logic [2:0] s);
    for (int k = 1; k <= 8; k++) if (m[(int'(s) + k) % 8]) return 3'((int'(s) + k) % 8);
    return s;
  endfunction

  task automatic model(input logic r, input logic e, input logic [7:0] m);
    logic [2:0] n;
    m_done = 1'b0;
    if (r) begin
      m_state = 0; m_cnt = 0; m_sel = 3'd0; m_vld = 1'b0;
    end else if (m_state == 0) begin
      m_cnt = 0;
      if (e && m != 8'd0) begin
        m_state = 1; m_sel = m_lowest(m); m_vld = 1'b1;
      end else m_vld = 1'b0;
    end else if (!e || m == 8'd0) begin
      m_state = 0; m_cnt = 0; m_vld = 1'b0;
    end else if (m_cnt == DIV - 1) begin
      m_cnt = 0;
      if (m_state == 1) begin
        n = m_next(m, m_sel);
        m_done = (n <= m_sel);
        m_sel = n;
`ifdef SCAN_BLANK_EN
        m_state = 2; m_vld = 1'b0;
`endif
      end else begin
        m_state = 1; m_vld = 1'b1;
      end
    end else begin
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, record the model's expectation, compare after the edge.
  task automatic step(input logic r, input logic e, input logic [7:0] m);
    exp_t x;
    rst = r; en = e; mask = m;
    model(r, e, m);
    q.push_back({m_sel, m_vld, m_done});
    @(posedge clk);
    #1;
    x = q.pop_front();
    check("sel", {5'd0, sel}, {5'd0, x.sel});
    check("sel_vld", {7'd0, sel_vld}, {7'd0, x.vld});
    check("scan_done", {7'd0, scan_done}, {7'd0, x.done});
    if (scan_done === 1'b1) done_cnt++;
  endtask

  initial begin
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'hFF);
    check("reset_sel", {5'd0, sel}, 8'd0);
    check("reset_vld", {7'd0, sel_vld}, 8'd0);

    // full mask: 0..7 then back to 0, one pass-complete pulse
    step(1'b0, 1'b1, 8'hFF);
    check("start_sel", {5'd0, sel}, 8'd0);
    done_cnt = 0;
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 8'hFF);
`ifndef SCAN_BLANK_EN
    check("ff_wrap_sel", {5'd0, sel}, 8'd0);
    check("ff_done_cnt", 8'(done_cnt), 8'd1);
    check("ff_vld", {7'd0, sel_vld}, 8'd1);
`endif

    // sparse mask 2,5,7,2
    done_cnt = 0;
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'hA4);
`ifndef SCAN_BLANK_EN
    check("a4_sel", {5'd0, sel}, 8'd2);
    check("a4_done_cnt", 8'(done_cnt), 8'd1);
`endif

    // single-bit mask: index stays, pulse each slot
    done_cnt = 0;
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h10);
`ifndef SCAN_BLANK_EN
    check("single_sel", {5'd0, sel}, 8'd4);
    check("single_done_cnt", 8'(done_cnt), 8'd3);
`endif

    // drop enable on the tick cycle, then restart at lowest set bit
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h10);
    step(1'b0, 1'b0, 8'h10);
    check("en_off_vld", {7'd0, sel_vld}, 8'd0);
    check("en_off_done", {7'd0, scan_done}, 8'd0);
    step(1'b0, 1'b1, 8'h60);
    check("restart_sel", {5'd0, sel}, 8'd5);
    check("restart_vld", {7'd0, sel_vld}, 8'd1);

    // reset mid-slot while sel=5
    step(1'b0, 1'b1, 8'h60);
    step(1'b1, 1'b1, 8'h60);
    check("midrst_sel", {5'd0, sel}, 8'd0);
    check("midrst_vld", {7'd0, sel_vld}, 8'd0);
    step(1'b0, 1'b1, 8'h60);
    check("postrst_sel", {5'd0, sel}, 8'd5);

    // mask cleared while scanning
    step(1'b0, 1'b1, 8'h00);
    check("mask0_vld", {7'd0, sel_vld}, 8'd0);

    // randomized traffic against the model
    begin
      logic [7:0] rm;
      rm = 8'h5A;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 7) == 0) rm = 8'($urandom_range(0, 255));
        step(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
             ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1, rm);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
